wb_mem_responder: RTL
=====================

Name: wb_mem_responder

Overview:
Pipelined Wishbone B4 responder that serves the instruction-fetch master and other bus masters from an internal word-addressed memory array. Accepts one request per cycle unless stalled. Returns ack plus read data after a fixed, parameterised latency. Sits on the memory side of the processor's Wishbone bus; it is the simulation and FPGA backing store for boot code.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, >= 2.
- LATENCY, 1, cycles from request acceptance to ack; 1..8.
- MAX_OUTSTANDING, LATENCY, maximum accepted-but-unacknowledged requests; 1..LATENCY.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- wb_adr_i  input  32  byte address; bits [1:0] ignored.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte lane enables for writes.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_stb_i  input  1  strobe.
- wb_cyc_i  input  1  cycle valid.
- wb_stall_o  output  1  request cannot be accepted this cycle.
- wb_ack_o  output  1  response valid.
- wb_err_o  output  1  error response (see Optional Feature).
- wb_dat_o  output  32  read data; 0 whenever wb_ack_o = 0.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - wb_ack_o = 0, wb_err_o = 0, wb_stall_o = 0, wb_dat_o = 0.
  - Response pipeline valid bits cleared; outstanding counter = 0.
  - Memory contents are not reset.
- Accept condition: wb_cyc_i & wb_stb_i & ~wb_stall_o sampled at a rising edge.
- Word index = wb_adr_i[log2(DEPTH)+1:2]; upper bits ignored (aliasing) unless WB_RESP_ERR_EN is defined.
- Read: memory word is read at the accept edge and carried down a LATENCY-stage shift register (valid, err, data).
- Write:
  - Each byte lane i with wb_sel_i[i] = 1 is updated at the accept edge.
  - A write is acked like a read, with wb_dat_o = 0.
- Ordering and latency:
  - A request accepted at edge k gives wb_ack_o = 1 for exactly one cycle, starting after edge k+LATENCY-1. With LATENCY = 1, ack is in the cycle immediately after acceptance.
  - Responses are returned strictly in order; back-to-back requests produce back-to-back acks.
  - A read accepted after a write to the same word returns the new data, including when the read is issued in the cycle directly after the write.
- Outstanding counter:
  - Increments on accept and decrements on ack.
  - Simultaneous accept and ack leaves the counter unchanged.
  - Width is clog2(MAX_OUTSTANDING+1).
- wb_stall_o = (outstanding == MAX_OUTSTANDING) & ~(ack this cycle). It is a combinational function of registered state only; it never depends on wb_stb_i.
- Abort: if wb_cyc_i = 0 in a cycle, then:
  - All pipeline valid bits clear at the next edge, and the counter returns to 0.
  - wb_ack_o and wb_err_o are gated low in that cycle.
  - Writes already accepted stay committed.
- Reset mid-operation: in-flight responses are dropped, with no late ack after reset release. Writes accepted before reset persist.
- No backpressure on responses; the master must accept every ack.

Optional Feature:
- Macro: WB_RESP_ERR_EN.
- Defined:
  - Any accepted request with wb_adr_i >= DEPTH*4 is an error.
  - For such a request, the memory is not written, and its response slot asserts wb_err_o = 1 instead of wb_ack_o, with the same latency and ordering as a normal response and wb_dat_o = 0.
  - The error does count toward outstanding requests.
- Not defined:
  - wb_err_o is tied to 0.
  - Out-of-range addresses alias onto the index bits.

Test Plan:
- LATENCY = 1: write 0xDEADBEEF to 0x10 (sel = 0xF), then read 0x10 on the next cycle -> ack one cycle after each accept; read returns 0xDEADBEEF.
- Byte lanes: word holds 0x11223344; write 0xAABBCCDD with sel = 0x5 -> read returns 0x11BB33DD.
- LATENCY = 3, MAX_OUTSTANDING = 2: three consecutive reads of 0x0, 0x4, 0x8 ->
  - wb_stall_o = 1 in the cycle after the second accept;
  - the third read is accepted in the cycle the first ack is asserted;
  - acks return in order with the correct data.
- Abort: LATENCY = 4; accept 2 reads, then drop wb_cyc_i for 1 cycle -> no ack ever observed; counter is 0; wb_stall_o = 0.
- Async reset asserted mid-flight (between edges) -> wb_ack_o falls immediately; no ack after release; a previously written word still reads back.
- WB_RESP_ERR_EN, DEPTH = 1024: read 0x1000 -> wb_err_o pulses at ack latency with wb_ack_o = 0. Write 0x1000 -> word 0 is unchanged.

Source files
------------

// File: rtl/wb_mem_responder_if.sv
// Pipelined Wishbone B4 bus bundle between a bus master and wb_mem_responder.
// Signal suffixes are named from the responder's point of view.
interface wb_mem_responder_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone B4 memory responder with fixed-latency in-order acks.
// Define WB_RESP_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
module wb_mem_responder #(
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_mem_responder_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [31:0]        r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_dat [LATENCY];
  logic [CW-1:0]      r_cnt;

  logic          w_resp;
  logic          w_stall;
  logic          w_accept;
  logic          w_oob;
  logic          w_write;
  logic          w_ack;
  logic [AW-1:0] w_idx;

  assign w_idx    = wb.wb_adr_i[AW+1:2];
  assign w_resp   = r_vld[LATENCY-1];
  // The slot leaving the pipe this cycle frees room, so a full counter only stalls without one.
  assign w_stall  = (r_cnt == MAX_CNT) & ~w_resp;
  assign w_accept = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall;
  assign w_write  = w_accept & wb.wb_we_i & ~w_oob & rst_i;

`ifdef WB_RESP_ERR_EN
  logic w_unused;
  assign w_oob    = |wb.wb_adr_i[31:AW+2];
  assign w_unused = ^wb.wb_adr_i[1:0];
`else
  logic w_unused;
  assign w_oob    = 1'b0;
  assign w_unused = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};
`endif

  // NOTE: the memory array has no reset; it holds boot code across rst_i.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) r_mem[w_idx][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  // Data stages need no reset: every consumer is qualified by r_vld.
  always_ff @(posedge clk_i) begin
    r_dat[0] <= (wb.wb_we_i | w_oob) ? '0 : r_mem[w_idx];
    for (int s = 1; s < LATENCY; s++) r_dat[s] <= r_dat[s-1];
  end

  // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else if (!wb.wb_cyc_i) begin
      r_vld <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      r_vld[0] <= w_accept;
      r_err[0] <= w_accept & w_oob;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_err[s] <= r_err[s-1];
      end
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_resp);
    end
  end

  // A dropped cycle suppresses any response that would have landed in it.
  assign w_ack         = wb.wb_cyc_i & w_resp & ~r_err[LATENCY-1];
  assign wb.wb_ack_o   = w_ack;
  assign wb.wb_stall_o = w_stall;
  assign wb.wb_dat_o   = w_ack ? r_dat[LATENCY-1] : '0;
`ifdef WB_RESP_ERR_EN
  assign wb.wb_err_o   = wb.wb_cyc_i & w_resp & r_err[LATENCY-1];
`else
  assign wb.wb_err_o   = 1'b0;
`endif
endmodule
